// File: rtl/tt_um_top_layer.sv
// Byte-serial sample bus feeding NUM_UNITS spike detectors.
// The selected unit's event code and spike flag appear on uo_out.
module tt_um_top_layer #(
   parameter int NUM_UNITS    = 2,
   parameter int DATA_WIDTH   = 16,
   parameter int AMP_THRESH   = 1000,
   parameter int SLOPE_THRESH = 800,
   parameter int REFRACTORY   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CW = $clog2(REFRACTORY + 1);
   localparam logic signed [16:0] AMP_P = 17'(AMP_THRESH);
   localparam logic signed [16:0] AMP_N = 17'(-AMP_THRESH);
   localparam logic [16:0] SLOPE = 17'(SLOPE_THRESH);

   typedef enum logic {PH_MSB, PH_LSB} phase_t;

   phase_t ph_q, ph_d;
   logic [7:0] hi_q;
   logic strb_q;
   logic [1:0] sel_q;
   logic [DATA_WIDTH-1:0] x_q;
   logic byte_valid;
   logic [2:0] res [4];
   logic [2:0] uo_q;
   logic unused;

   assign byte_valid = ui_in[2];
   assign unused = &{1'b0, ena, ui_in[7:3]};

   always_comb begin
      ph_d = ph_q;
      if (byte_valid) begin
         ph_d = (ph_q == PH_MSB) ? PH_LSB : PH_MSB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q   <= PH_MSB;
         hi_q   <= '0;
         strb_q <= 1'b0;
         sel_q  <= '0;
         x_q    <= '0;
      end else begin
         ph_q   <= ph_d;
         strb_q <= byte_valid && (ph_q == PH_LSB);
         if (byte_valid && ph_q == PH_MSB) begin
            hi_q <= uio_in;
         end
         if (byte_valid && ph_q == PH_LSB) begin
            x_q   <= {hi_q, uio_in};
            sel_q <= ui_in[1:0];
         end
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_u
      if (i < NUM_UNITS) begin : g_on
         logic [CW-1:0] cnt_q;
         logic [DATA_WIDTH-1:0] prev_q;
         logic [1:0] evt_q, evt_d;
         logic spk_q;
         logic signed [16:0] xs, ps, diff;
         logic [16:0] mag;

         // 17-bit difference cannot overflow for 16-bit operands
         always_comb begin
            xs    = {x_q[15], x_q};
            ps    = {prev_q[15], prev_q};
            diff  = xs - ps;
            mag   = diff[16] ? 17'(-diff) : 17'(diff);
            evt_d = 2'b00;
            if (xs >= AMP_P) begin
               evt_d = 2'b01;
            end else if (xs <= AMP_N) begin
               evt_d = 2'b10;
            end else if (mag >= SLOPE) begin
               evt_d = 2'b11;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q  <= '0;
               prev_q <= '0;
               evt_q  <= 2'b00;
               spk_q  <= 1'b0;
            end else if (strb_q && sel_q == 2'(i)) begin
               prev_q <= x_q;
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
                  evt_q <= 2'b00;
                  spk_q <= 1'b0;
               end else begin
                  evt_q <= evt_d;
                  spk_q <= (evt_d != 2'b00);
                  if (evt_d != 2'b00) begin
                     cnt_q <= CW'(REFRACTORY);
                  end
               end
            end
         end

         assign res[i] = {evt_q, spk_q};
      end else begin : g_off
         assign res[i] = 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_q <= 3'b000;
      end else begin
         uo_q <= res[ui_in[1:0]];
      end
   end

   assign uo_out  = {5'b00000, uo_q};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_top_layer.sv
// Vector-table bench for tt_um_top_layer with an expected-value queue.
// Expected uo_out values are hand-derived constants in the table.
module tb_tt_um_top_layer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic [7:0] ui_in = '0;
   logic [7:0] uio_in = '0;
   logic [7:0] uo_out, uio_out, uio_oe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         only_view;
      logic [1:0] sel_msb;
      logic [1:0] sel_lsb;
      logic [1:0] view;
      logic [15:0] x;
      logic [2:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] exp_q[$];
   localparam int RST_IDX = 21;

   tt_um_top_layer dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo_out),
      .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(bit ov, logic [1:0] sm, logic [1:0] sl,
                      logic [1:0] vw, logic [15:0] x,
                      logic [2:0] e, string nm);
      vec_t v;
      v.only_view = ov; v.sel_msb = sm; v.sel_lsb = sl;
      v.view = vw; v.x = x; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic run(vec_t v);
      if (!v.only_view) begin
         @(negedge clk);
         ui_in = {5'd0, 1'b1, v.sel_msb};
         uio_in = v.x[15:8];
         @(negedge clk);
         ui_in = {5'd0, 1'b1, v.sel_lsb};
         uio_in = v.x[7:0];
         @(posedge clk);
         #1;
      end else begin
         @(negedge clk);
      end
      exp_q.push_back({5'd0, v.exp});
      ui_in = {5'd0, 1'b0, v.view};
      uio_in = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk(v.name, uo_out, exp_q.pop_front());
      chk({v.name, "_uio"}, {uio_out | uio_oe}, 8'h00);
   endtask

   initial begin
      add(0, 0, 0, 0, 16'd500,  3'b000, "u0_500");
      add(0, 0, 0, 0, 16'd1200, 3'b011, "u0_1200");
      add(0, 0, 0, 0, 16'd2000, 3'b000, "u0_ref1");
      add(0, 0, 0, 0, 16'd2000, 3'b000, "u0_ref2");
      add(0, 0, 0, 0, 16'd2000, 3'b000, "u0_ref3");
      add(0, 0, 0, 0, 16'd2000, 3'b000, "u0_ref4");
      add(0, 0, 0, 0, 16'd2000, 3'b011, "u0_after_ref");
      add(0, 1, 1, 1, 16'hFC18, 3'b101, "u1_neg1000");
      add(0, 1, 1, 1, 16'd0,    3'b000, "u1_ref1");
      add(0, 1, 1, 1, 16'd0,    3'b000, "u1_ref2");
      add(0, 1, 1, 1, 16'd0,    3'b000, "u1_ref3");
      add(0, 1, 1, 1, 16'd0,    3'b000, "u1_ref4");
      add(0, 1, 1, 1, 16'd700,  3'b000, "u1_700");
      add(0, 1, 1, 1, 16'd0,    3'b000, "u1_slope_m700");
      add(0, 1, 1, 1, 16'd700,  3'b000, "u1_700b");
      add(0, 1, 1, 1, 16'hFF38, 3'b111, "u1_slope_m900");
      add(0, 3, 3, 3, 16'h7FFF, 3'b000, "drop_sel3");
      add(1, 0, 0, 0, 16'd0,    3'b011, "view_u0_held");
      add(1, 0, 0, 1, 16'd0,    3'b111, "view_u1_held");
      add(0, 1, 0, 0, 16'd100,  3'b000, "sel_swap_u0");
      add(1, 0, 0, 1, 16'd0,    3'b111, "u1_untouched");
      add(0, 0, 0, 0, 16'h000A, 3'b000, "post_rst_10");
      add(0, 0, 0, 0, 16'd1000, 3'b011, "amp_boundary");
      add(0, 1, 1, 1, 16'd799,  3'b000, "slope_799");
      add(0, 1, 1, 1, 16'hFFFF, 3'b111, "slope_800");
      add(1, 0, 0, 0, 16'd0,    3'b011, "view_u0_final");

      #12;
      chk("reset_uo", uo_out, 8'h00);
      chk("reset_uio", {uio_out | uio_oe}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == RST_IDX) begin
            @(negedge clk);
            ui_in = 8'h04;
            uio_in = 8'h12;
            @(negedge clk);
            ui_in = 8'h00;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_uo", uo_out, 8'h00);
            @(negedge clk);
            rst_n = 1'b1;
         end
         run(vecs[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
